// File: rtl/reaction_timer_multi.sv
// ============================================================================
//  Module      : reaction_timer_multi
//  Description : Multi-trial reaction timer with random pre-delay, timeout,
//                best-time and session-average statistics.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module reaction_timer_multi #(
    parameter int TICK_DIV     = 100000,
    parameter int MS_W         = 14,
    parameter int MAX_MS       = 1000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RND_W        = 12,
    parameter int N_TRIALS     = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               stop,
    input  logic                               clear,
    input  logic [RND_W-1:0]                   rnd,
    output logic                               led,
    output logic [1:0]                         disp_sel,
    output logic [MS_W-1:0]                    disp_val,
    output logic                               result_valid,
    output logic                               timeout,
    output logic [MS_W-1:0]                    best_ms,
    output logic [MS_W-1:0]                    avg_ms,
    output logic [$clog2(N_TRIALS+1)-1:0]      trial_idx
);

    localparam int c_log2n = $clog2(N_TRIALS);
    localparam int c_sum_w = MS_W + c_log2n;
    localparam int c_idx_w = $clog2(N_TRIALS + 1);
    localparam int c_ps_w  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [c_ps_w-1:0]  c_ps_last  = c_ps_w'(TICK_DIV - 1);
    localparam logic [MS_W-1:0]    c_max_ms   = MS_W'(MAX_MS);
    localparam logic [MS_W-1:0]    c_min_dly  = MS_W'(MIN_DELAY_MS);
    localparam logic [c_idx_w-1:0] c_n_trials = c_idx_w'(N_TRIALS);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_wait = 3'd1;
    localparam logic [2:0] c_st_test = 3'd2;
    localparam logic [2:0] c_st_show = 3'd3;
    localparam logic [2:0] c_st_err  = 3'd4;
    localparam logic [2:0] c_st_done = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_ps_w-1:0]  r_presc;
    logic [MS_W-1:0]    r_ms;
    logic [MS_W-1:0]    r_delay;
    logic [MS_W-1:0]    r_result;
    logic               r_result_valid;
    logic               r_timeout;
    logic [MS_W-1:0]    r_best;
    logic [c_sum_w-1:0] r_sum;
    logic [c_idx_w-1:0] r_trial_idx;

    logic               w_tick;
    logic [MS_W-1:0]    w_ms_next;
    logic               w_enter_wait;
    logic               w_enter_test;
    logic               w_capture;
    logic               w_cap_to;
    logic [MS_W-1:0]    w_cap_val;
    logic [MS_W-1:0]    w_avg;

    assign w_tick    = (r_presc == c_ps_last);
    assign w_ms_next = r_ms + MS_W'(w_tick);
    assign w_avg     = MS_W'(r_sum >> c_log2n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A stop landing on the final tick takes w_ms_next == MAX_MS as a normal reaction.
    always_comb begin
        w_state_nxt  = r_state;
        w_enter_wait = 1'b0;
        w_enter_test = 1'b0;
        w_capture    = 1'b0;
        w_cap_to     = 1'b0;
        w_cap_val    = w_ms_next;
        if (clear) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        w_state_nxt  = c_st_wait;
                        w_enter_wait = 1'b1;
                    end
                end
                c_st_wait: begin
                    if (stop) begin
                        w_state_nxt = c_st_err;
                    end else if (w_tick && (w_ms_next >= r_delay)) begin
                        w_state_nxt  = c_st_test;
                        w_enter_test = 1'b1;
                    end
                end
                c_st_test: begin
                    if (stop) begin
                        w_state_nxt = c_st_show;
                        w_capture   = 1'b1;
                    end else if (w_tick && (w_ms_next >= c_max_ms)) begin
                        w_state_nxt = c_st_show;
                        w_capture   = 1'b1;
                        w_cap_to    = 1'b1;
                        w_cap_val   = c_max_ms;
                    end
                end
                c_st_show: begin
                    if (start) begin
                        if (r_trial_idx < c_n_trials) begin
                            w_state_nxt  = c_st_wait;
                            w_enter_wait = 1'b1;
                        end else begin
                            w_state_nxt = c_st_done;
                        end
                    end
                end
                c_st_err: begin
                    if (start) begin
                        w_state_nxt  = c_st_wait;
                        w_enter_wait = 1'b1;
                    end
                end
                c_st_done: begin
                    w_state_nxt = c_st_done;
                end
                default: begin
                    w_state_nxt = c_st_idle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc        <= '0;
            r_ms           <= '0;
            r_delay        <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_timeout      <= 1'b0;
            r_best         <= '1;
            r_sum          <= '0;
            r_trial_idx    <= '0;
        end else begin
            r_result_valid <= w_capture;
            if (clear) begin
                r_presc     <= '0;
                r_ms        <= '0;
                r_result    <= '0;
                r_timeout   <= 1'b0;
                r_best      <= '1;
                r_sum       <= '0;
                r_trial_idx <= '0;
            end else begin
                if (w_enter_wait || w_enter_test) begin
                    r_presc <= '0;
                    r_ms    <= '0;
                end else begin
                    r_presc <= w_tick ? '0 : r_presc + c_ps_w'(1);
                    r_ms    <= w_ms_next;
                end
                if (w_enter_wait) begin
                    r_delay   <= c_min_dly + MS_W'(rnd);
                    r_timeout <= 1'b0;
                end
                if (w_capture) begin
                    r_result    <= w_cap_val;
                    r_timeout   <= w_cap_to;
                    r_trial_idx <= r_trial_idx + c_idx_w'(1);
                    r_sum       <= r_sum + c_sum_w'(w_cap_val);
                    if (w_cap_val < r_best) begin
                        r_best <= w_cap_val;
                    end
                end
            end
        end
    end

    always_comb begin
        led      = (r_state == c_st_test);
        disp_sel = 2'd0;
        disp_val = '0;
        case (r_state)
            c_st_wait: disp_sel = 2'd1;
            c_st_test: disp_sel = 2'd1;
            c_st_show: begin
                disp_sel = 2'd2;
                disp_val = r_result;
            end
            c_st_err:  disp_sel = 2'd3;
            c_st_done: begin
                disp_sel = 2'd2;
                disp_val = w_avg;
            end
            default:   disp_sel = 2'd0;
        endcase
    end

    assign result_valid = r_result_valid;
    assign timeout      = r_timeout;
    assign best_ms      = r_best;
    assign avg_ms       = w_avg;
    assign trial_idx    = r_trial_idx;

endmodule

`default_nettype wire
